// File: rtl/rptr_empty_lvl.sv
// rtl/rptr_empty_lvl.sv - async FIFO read pointer, empty/almost-empty flags and fill level
// Optional sticky underflow detector enabled by defining RPTR_UFLOW_EN.

module rptr_empty_lvl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr_sync,
`ifdef RPTR_UFLOW_EN
    input  logic                  uflow_clr,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rlevel
);

    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] rbin_next;
    logic [ADDR_WIDTH:0] rgray_next;
    logic [ADDR_WIDTH:0] wbin_sync;
    logic [ADDR_WIDTH:0] lvl_next;
    logic                pop;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            wbin_sync[i] = ^(wptr_sync >> i);
        end
    end

    always_comb begin
        pop        = rinc & ~empty;
        rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        lvl_next   = wbin_sync - rbin_next;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            rbin         <= '0;
            rptr         <= '0;
            raddr        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
        end else begin
            rbin         <= rbin_next;
            rptr         <= rgray_next;
            raddr        <= rbin_next[ADDR_WIDTH-1:0];
            empty        <= (rgray_next == wptr_sync);
            rlevel       <= lvl_next;
            almost_empty <= (lvl_next <= AE_LVL);
        end
    end

`ifdef RPTR_UFLOW_EN
    // Set has priority over clear so a same-cycle underflow is never lost.
    always_ff @(posedge rclk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (rinc && empty) begin
            underflow <= 1'b1;
        end else if (uflow_clr) begin
            underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb/tb_rptr_empty_lvl.sv - table-driven bench for rptr_empty_lvl (ADDR_WIDTH=3, AE_THRESH=1)

module tb_rptr_empty_lvl;

    logic       rclk = 1'b0;
    logic       rst;
    logic       rinc;
    logic [3:0] wptr_sync;
    logic       uflow_clr;
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rlevel;
`ifdef RPTR_UFLOW_EN
    logic       underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rptr_empty_lvl #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
        .rclk         (rclk),
        .rst          (rst),
        .rinc         (rinc),
        .wptr_sync    (wptr_sync),
`ifdef RPTR_UFLOW_EN
        .uflow_clr    (uflow_clr),
        .underflow    (underflow),
`endif
        .rptr         (rptr),
        .raddr        (raddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel)
    );

    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst;
        logic       rinc;
        logic [3:0] w;
        logic [3:0] rptr;
        logic [2:0] raddr;
        logic       e;
        logic       ae;
        logic [3:0] lvl;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic r, input logic i, input logic [3:0] w,
                                input logic [3:0] p, input logic [2:0] a,
                                input logic e, input logic ae, input logic [3:0] l);
        vec_t v;
        v.rst = r; v.rinc = i; v.w = w; v.rptr = p; v.raddr = a;
        v.e = e; v.ae = ae; v.lvl = l;
        return v;
    endfunction

    function automatic logic [3:0] gray(input logic [3:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic i, input logic [3:0] w, input logic c);
        rst = r; rinc = i; wptr_sync = w; uflow_clr = c;
        @(posedge rclk);
        #1;
    endtask

    logic [3:0] prev_rptr;

    initial begin
        rst = 1'b1; rinc = 1'b0; wptr_sync = '0; uflow_clr = 1'b0;

        // reset with data pending, release
        vt[0]  = mk(1, 0, 4'b0111, 4'b0000, 0, 1, 1, 0);
        vt[1]  = mk(1, 0, 4'b0111, 4'b0000, 0, 1, 1, 0);
        vt[2]  = mk(0, 0, 4'b0111, 4'b0000, 0, 0, 0, 5);
        // drain three words, extra rinc ignored while empty
        vt[3]  = mk(1, 0, 4'b0010, 4'b0000, 0, 1, 1, 0);
        vt[4]  = mk(0, 1, 4'b0010, 4'b0000, 0, 0, 0, 3);
        vt[5]  = mk(0, 1, 4'b0010, 4'b0001, 1, 0, 0, 2);
        vt[6]  = mk(0, 1, 4'b0010, 4'b0011, 2, 0, 1, 1);
        vt[7]  = mk(0, 1, 4'b0010, 4'b0010, 3, 1, 1, 0);
        vt[8]  = mk(0, 1, 4'b0010, 4'b0010, 3, 1, 1, 0);
        vt[9]  = mk(0, 1, 4'b0010, 4'b0010, 3, 1, 1, 0);
        // full level then drain to empty
        vt[10] = mk(1, 0, 4'b1100, 4'b0000, 0, 1, 1, 0);
        vt[11] = mk(0, 0, 4'b1100, 4'b0000, 0, 0, 0, 8);
        vt[12] = mk(0, 1, 4'b1100, 4'b0001, 1, 0, 0, 7);
        vt[13] = mk(0, 1, 4'b1100, 4'b0011, 2, 0, 0, 6);
        vt[14] = mk(0, 1, 4'b1100, 4'b0010, 3, 0, 0, 5);
        vt[15] = mk(0, 1, 4'b1100, 4'b0110, 4, 0, 0, 4);
        vt[16] = mk(0, 1, 4'b1100, 4'b0111, 5, 0, 0, 3);
        vt[17] = mk(0, 1, 4'b1100, 4'b0101, 6, 0, 0, 2);
        vt[18] = mk(0, 1, 4'b1100, 4'b0100, 7, 0, 1, 1);
        vt[19] = mk(0, 1, 4'b1100, 4'b1100, 0, 1, 1, 0);
        // two writes land, then pop with a simultaneous write
        vt[20] = mk(0, 0, 4'b1111, 4'b1100, 0, 0, 0, 2);
        vt[21] = mk(0, 1, 4'b1110, 4'b1101, 1, 0, 0, 2);

        for (int k = 0; k < 22; k++) begin
            step(vt[k].rst, vt[k].rinc, vt[k].w, 1'b0);
            check($sformatf("v%0d_rptr", k),  rptr,         vt[k].rptr);
            check($sformatf("v%0d_raddr", k), raddr,        vt[k].raddr);
            check($sformatf("v%0d_empty", k), empty,        vt[k].e);
            check($sformatf("v%0d_ae", k),    almost_empty, vt[k].ae);
            check($sformatf("v%0d_lvl", k),   rlevel,       vt[k].lvl);
        end

        // wrap: 15 pop/write pairs bring rbin to 15, then pop to 0
        step(1, 0, 4'b0000, 0);
`ifdef RPTR_UFLOW_EN
        check("uflow_reset", underflow, 0);
`endif
        step(0, 0, gray(4'd1), 0);
        check("wrap_prime_lvl", rlevel, 1);
        prev_rptr = rptr;
        for (int k = 1; k <= 15; k++) begin
            step(0, 1, gray(4'(k + 1)), 0);
            check($sformatf("wrap%0d_rptr", k), rptr, gray(4'(k)));
            check($sformatf("wrap%0d_lvl", k), rlevel, 1);
            check($sformatf("wrap%0d_1bit", k), int'($countones(rptr ^ prev_rptr)) <= 1, 1);
            prev_rptr = rptr;
        end
        check("wrap15_raddr", raddr, 7);
        step(0, 1, 4'b0000, 0);
        check("wrap_rptr", rptr, 0);
        check("wrap_raddr", raddr, 0);
        check("wrap_empty", empty, 1);
        check("wrap_lvl", rlevel, 0);
        check("wrap_ae", almost_empty, 1);

`ifdef RPTR_UFLOW_EN
        step(0, 1, 4'b0000, 0);
        check("uflow_set", underflow, 1);
        check("uflow_rptr_hold", rptr, 0);
        step(0, 1, 4'b0000, 1);
        check("uflow_set_wins", underflow, 1);
        step(0, 0, 4'b0000, 1);
        check("uflow_clr", underflow, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rptr_empty_lvl.md
Name: rptr_empty_lvl

Overview:
- Read-side pointer and status block for the async FIFO.
- Successor to the basic read-pointer/empty block. Adds:
  - a Gray-to-binary decode of the synchronised write pointer;
  - a registered fill level;
  - a programmable almost-empty flag;
  - an optional sticky underflow detector.
- Sits in the read clock domain between the 2-flop wptr synchroniser and the dual-port RAM read port.

Parameters:
- ADDR_WIDTH, 3, RAM address width; DEPTH = 2**ADDR_WIDTH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- rclk  in  1  read clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rinc  in  1  pop request
- wptr_sync  in  ADDR_WIDTH+1  Gray write pointer, already synchronised into rclk
- rptr  out  ADDR_WIDTH+1  Gray read pointer to the write-domain synchroniser (registered)
- raddr  out  ADDR_WIDTH  RAM read address (registered)
- empty  out  1  FIFO empty (registered)
- almost_empty  out  1  level <= AE_THRESH (registered)
- rlevel  out  ADDR_WIDTH+1  words available, 0..DEPTH (registered)
- uflow_clr  in  1  clears underflow; present only with RPTR_UFLOW_EN
- underflow  out  1  sticky underflow; present only with RPTR_UFLOW_EN

Behaviour:
- Reset: one clock and reset, as already decided. rclk is the only clock. rst is synchronous and active-high; it is sampled on rising rclk.
  - While rst=1 at an edge: rbin=0, rptr=0, raddr=0, empty=1, almost_empty=1, rlevel=0, underflow=0.
  - Reset mid-stream discards pointer state immediately. The next state is derived from wptr_sync on the first edge with rst=0.
- Pop acceptance:
  - pop = rinc & ~empty, using the registered empty.
  - A rinc while empty is ignored: rbin does not move.
- Per-cycle arithmetic (all ADDR_WIDTH+1 bits, modulo 2**(ADDR_WIDTH+1)):
  - rbin_next = rbin + pop
  - rgray_next = (rbin_next >> 1) ^ rbin_next
  - wbin_sync = Gray-to-binary of wptr_sync, combinational XOR prefix from the MSB
  - lvl_next = wbin_sync - rbin_next
- Register updates on each non-reset edge:
  - rbin <= rbin_next
  - rptr <= rgray_next
  - raddr <= rbin_next[ADDR_WIDTH-1:0]
  - empty <= (rgray_next == wptr_sync)
  - rlevel <= lvl_next
  - almost_empty <= (lvl_next <= AE_THRESH)
- Latency:
  - A pop in cycle N updates rptr, raddr, empty and rlevel at edge N+1.
  - A wptr_sync change at edge N is reflected at edge N+1. No extra pipeline stage.
- Boundaries:
  - Wrap: rbin from 2**(ADDR_WIDTH+1)-1 rolls to 0. rptr follows Gray wrap; no special case.
  - Full: wbin_sync - rbin_next = DEPTH gives rlevel=DEPTH (MSB set, low bits 0), empty=0.
  - Last word: a pop when rlevel=1 with no write gives empty=1, rlevel=0, almost_empty=1 on the next edge.
  - Simultaneous pop and wptr advance: the level is computed from both. Example: level 2, pop plus one write gives 2.
  - AE_THRESH=0: almost_empty is equivalent to empty.
- Stability: rptr changes at most one bit per edge (Gray, single pop).

Optional Feature:
- Macro: RPTR_UFLOW_EN.
- Defined:
  - underflow <= 1 on any edge where rinc=1 and empty=1.
  - Otherwise it clears when uflow_clr=1. Set wins over clear in the same cycle.
  - Reset clears it.
  - uflow_clr and underflow ports exist.
- Undefined: both ports are absent and there is no underflow logic. Main-path behaviour is identical.

Test Plan:
All cases use ADDR_WIDTH=3, AE_THRESH=1.
1. Reset: hold rst=1 for 2 edges with wptr_sync=4'b0111 (bin 5) -> empty=1, almost_empty=1, rlevel=0, rptr=0. After rst drops -> next edge empty=0, rlevel=5, almost_empty=0.
2. Drain: wptr_sync=4'b0010 (bin 3), rinc held 5 cycles ->
   - rptr 0001, 0011, 0010, then holds;
   - rlevel 2, 1, 0;
   - almost_empty at rlevel=1;
   - empty=1 after the third pop; raddr stops at 3.
3. Full/level: rbin=0, wptr_sync=4'b1100 (bin 8) -> rlevel=8 (4'b1000), empty=0, almost_empty=0. Pop every cycle -> rlevel counts 7..0 and empty asserts at 0.
4. Wrap: preload via 15 pop/write pairs to rbin=15, wptr_sync=gray(0)=4'b0000 -> one pop gives rbin=0, rptr=4'b0000, empty=1, raddr=0.
5. Simultaneous: rlevel=2, pop while wptr_sync advances by one -> rlevel stays 2, empty=0, rptr advances one Gray step.
6. With RPTR_UFLOW_EN: empty=1, rinc=1 one cycle -> underflow=1 and rptr unchanged. rinc=1 and uflow_clr=1 together -> underflow stays 1. uflow_clr alone -> underflow=0 next edge.
